// File: rtl/panda_pkg.sv
// Shared types and constants for the panda decode stage.
// Optional feature macro used by the stage: PANDA_RF_BYPASS_EN.
package panda_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} alu_src_a_e;

  typedef enum logic {SRC_B_RS2, SRC_B_IMM} alu_src_b_e;

  typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_e;

  typedef enum logic [2:0] {
    BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4,
    BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7
  } branch_cond_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_inc;
  } if_id_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  rs1_data;
    logic [31:0]  rs2_data;
    logic [31:0]  imm;
    alu_op_e      alu_op;
    alu_src_a_e   alu_src_a;
    alu_src_b_e   alu_src_b;
    logic         reg_we;
    logic         mem_read;
    logic         mem_write;
    mem_size_e    mem_size;
    logic         mem_unsigned;
    logic         branch;
    branch_cond_e branch_cond;
    logic         jump;
    logic         jalr;
  } id_ex_t;

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/panda_regfile.sv
// Integer register file: two combinational read ports, one write port.
// x0 is hard-wired to zero. PANDA_RF_BYPASS_EN forwards same-cycle write data.
module panda_regfile
  import panda_pkg::*;
#(
  parameter int unsigned NumRegs = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_d [NumRegs];
  logic [31:0] regs_q [NumRegs];

  // next-state of the array: single write, x0 never updated
  always_comb begin
    regs_d = regs_q;
    if (we_i && waddr_i != '0) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // storage with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // read ports
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef PANDA_RF_BYPASS_EN
    if (we_i && waddr_i != '0 && waddr_i == raddr_a_i) rdata_a_o = wdata_i;
    if (we_i && waddr_i != '0 && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/panda_id_stage.sv
// RV32I decode stage: decode, operand read, load-use / writeback hazard stall,
// and the registered ID/EX record. PANDA_RF_BYPASS_EN enables regfile bypass;
// without it a same-cycle writeback to a used source stalls one cycle.
module panda_id_stage
  import panda_pkg::*;
#(
  parameter int unsigned NumRegs = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  if_id_t      if_id_i,
  input  logic        flush_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        stall_o,
  output logic        illegal_instr_o,
  output id_ex_t      id_ex_o
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        alu_alt;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_used, rs2_used, legal;
  logic        load_use_haz, wb_raw_haz;
  id_ex_t      dec;
  id_ex_t      id_ex_d, id_ex_q;
  logic        illegal_d, illegal_q;

  assign instr  = if_id_i.instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign alu_alt = instr[30] && (opcode == OPC_OP || funct3 == 3'd5);

  panda_regfile #(
    .NumRegs(NumRegs)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .raddr_a_i (rs1),
    .rdata_a_o (rs1_data),
    .raddr_b_i (rs2),
    .rdata_b_o (rs2_data),
    .we_i      (wb_we_i),
    .waddr_i   (wb_waddr_i),
    .wdata_i   (wb_wdata_i)
  );

  // instruction decode into a candidate ID/EX record
  always_comb begin
    dec          = '0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    legal        = 1'b1;
    dec.valid    = 1'b1;
    dec.pc       = if_id_i.pc;
    dec.pc_inc   = if_id_i.pc_inc;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    case (opcode)
      OPC_LUI: begin
        dec.imm = imm_u; dec.alu_src_a = SRC_A_ZERO; dec.alu_src_b = SRC_B_IMM; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_src_a = SRC_A_PC; dec.alu_src_b = SRC_B_IMM; dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.alu_src_a = SRC_A_PC; dec.alu_src_b = SRC_B_IMM;
        dec.reg_we = 1'b1; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_src_b = SRC_B_IMM; dec.reg_we = 1'b1;
        dec.jump = 1'b1; dec.jalr = 1'b1; rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1; dec.branch_cond = branch_cond_e'(funct3);
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_src_b = SRC_B_IMM; dec.reg_we = 1'b1; dec.mem_read = 1'b1;
        dec.mem_size = mem_size_e'(funct3[1:0]); dec.mem_unsigned = funct3[2]; rs1_used = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_src_b = SRC_B_IMM; dec.mem_write = 1'b1;
        dec.mem_size = mem_size_e'(funct3[1:0]); rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i; dec.alu_src_b = SRC_B_IMM; dec.reg_we = 1'b1;
        dec.alu_op = alu_op_decode(funct3, alu_alt); rs1_used = 1'b1;
      end
      OPC_OP: begin
        dec.reg_we = 1'b1; dec.alu_op = alu_op_decode(funct3, alu_alt);
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
      end
      default: legal = 1'b0;
    endcase
  end

  // hazard detection; flush overrides any stall
  always_comb begin
    load_use_haz = ex_mem_read_i && (ex_rd_i != '0) &&
                   ((rs1_used && ex_rd_i == rs1) || (rs2_used && ex_rd_i == rs2));
`ifdef PANDA_RF_BYPASS_EN
    wb_raw_haz   = 1'b0;
`else
    wb_raw_haz   = wb_we_i && (wb_waddr_i != '0) &&
                   ((rs1_used && wb_waddr_i == rs1) || (rs2_used && wb_waddr_i == rs2));
`endif
    stall_o      = !flush_i && (load_use_haz || wb_raw_haz);
  end

  // next ID/EX record: bubble on flush, stall, illegal or all-zero instruction
  always_comb begin
    id_ex_d   = dec;
    illegal_d = !legal && (instr != '0) && !flush_i;
    if (flush_i || stall_o || !legal) begin
      id_ex_d = '0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_ex_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      id_ex_q   <= id_ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign id_ex_o         = id_ex_q;
  assign illegal_instr_o = illegal_q;

endmodule

// File: tb/tb_panda_id_stage.sv
// Self-checking bench for panda_id_stage: directed scenarios plus randomized
// decode against a format-table reference model. Honours PANDA_RF_BYPASS_EN.
module tb_panda_id_stage;
  import panda_pkg::*;

`ifdef PANDA_RF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  localparam int F_ZERO = 0, F_ILL = 1, F_NOP = 2, F_U = 3, F_J = 4,
                 F_I = 5, F_S = 6, F_B = 7, F_R = 8;

  typedef struct packed {
    logic   stall;
    logic   illegal;
    logic   bubble;
    id_ex_t rec;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  if_id_t      if_id;
  logic        flush, emr, we;
  logic [4:0]  erd, wa;
  logic [31:0] wd;
  logic        stall, illegal;
  id_ex_t      id_ex;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] mregs [32];
  logic [31:0] pc_cnt;
  exp_t        expv;
  logic        stall_s;

  always #5 clk = ~clk;

  panda_id_stage #(.NumRegs(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .if_id_i         (if_id),
    .flush_i         (flush),
    .ex_mem_read_i   (emr),
    .ex_rd_i         (erd),
    .wb_we_i         (we),
    .wb_waddr_i      (wa),
    .wb_wdata_i      (wd),
    .stall_o         (stall),
    .illegal_instr_o (illegal),
    .id_ex_o         (id_ex)
  );

  function automatic logic [6:0] ctl(input id_ex_t r);
    return {r.valid, r.reg_we, r.mem_read, r.mem_write, r.branch, r.jump, r.jalr};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (Bypass && we && wa == a) return wd;
    return mregs[a];
  endfunction

  // Reference: classify by format, then derive every field from that class.
  function automatic exp_t model(input if_id_t f);
    logic [31:0]        ins, s20, s25, s31, imm;
    logic signed [31:0] sx;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [4:0]         r1, r2;
    logic               use1, use2, lu, raw, alt;
    int                 fmt;
    alu_op_e            ops [8];
    exp_t               e;
    ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    ins = f.instr; opc = ins[6:0]; f3 = ins[14:12]; r1 = ins[19:15]; r2 = ins[24:20];
    if (ins == 32'd0) fmt = F_ZERO;
    else if (opc == OPC_LUI || opc == OPC_AUIPC) fmt = F_U;
    else if (opc == OPC_JAL) fmt = F_J;
    else if (opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_OP_IMM) fmt = F_I;
    else if (opc == OPC_STORE) fmt = F_S;
    else if (opc == OPC_BRANCH) fmt = F_B;
    else if (opc == OPC_OP) fmt = F_R;
    else if (opc == OPC_MISC_MEM || opc == OPC_SYSTEM) fmt = F_NOP;
    else fmt = F_ILL;
    use1 = (fmt == F_I || fmt == F_S || fmt == F_B || fmt == F_R);
    use2 = (fmt == F_S || fmt == F_B || fmt == F_R);
    lu  = emr && erd != 0 && ((use1 && erd == r1) || (use2 && erd == r2));
    raw = !Bypass && we && wa != 0 && ((use1 && wa == r1) || (use2 && wa == r2));
    e = '0;
    e.stall   = !flush && (lu || raw);
    e.illegal = (fmt == F_ILL) && !flush;
    e.bubble  = flush || e.stall || fmt == F_ILL || fmt == F_ZERO;
    sx  = $signed(ins);
    s20 = sx >>> 20;
    s25 = sx >>> 25;
    s31 = sx >>> 31;
    case (fmt)
      F_I:     imm = s20;
      F_S:     imm = (s25 << 5) | 32'(ins[11:7]);
      F_B:     imm = (s31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      F_U:     imm = ins & 32'hFFFF_F000;
      F_J:     imm = (s31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: imm = 32'd0;
    endcase
    e.rec.valid    = 1'b1;
    e.rec.pc       = f.pc;
    e.rec.pc_inc   = f.pc_inc;
    e.rec.rs1      = r1;
    e.rec.rs2      = r2;
    e.rec.rd       = ins[11:7];
    e.rec.rs1_data = rf_read(r1);
    e.rec.rs2_data = rf_read(r2);
    e.rec.imm      = imm;
    if (opc == OPC_LUI) e.rec.alu_src_a = SRC_A_ZERO;
    if (opc == OPC_AUIPC || opc == OPC_JAL) e.rec.alu_src_a = SRC_A_PC;
    if (fmt == F_U || fmt == F_J || fmt == F_I || fmt == F_S) e.rec.alu_src_b = SRC_B_IMM;
    e.rec.reg_we    = (fmt == F_U || fmt == F_J || fmt == F_I || fmt == F_R);
    e.rec.mem_read  = (opc == OPC_LOAD);
    e.rec.mem_write = (opc == OPC_STORE);
    if (opc == OPC_LOAD || opc == OPC_STORE) e.rec.mem_size = mem_size_e'(ins[13:12]);
    e.rec.mem_unsigned = (opc == OPC_LOAD) && ins[14];
    e.rec.branch = (fmt == F_B);
    if (fmt == F_B) e.rec.branch_cond = branch_cond_e'(f3);
    e.rec.jump = (opc == OPC_JAL || opc == OPC_JALR);
    e.rec.jalr = (opc == OPC_JALR);
    if (opc == OPC_OP || opc == OPC_OP_IMM) begin
      e.rec.alu_op = ops[f3];
      alt = ins[30] && (opc == OPC_OP || f3 == 3'd5);
      if (alt && f3 == 3'd0) e.rec.alu_op = ALU_SUB;
      if (alt && f3 == 3'd5) e.rec.alu_op = ALU_SRA;
    end
    return e;
  endfunction

  // Apply one cycle of inputs (from just after a rising edge), record the
  // model expectation and the stall seen mid-cycle, end just after the next edge.
  task automatic drive_cycle(input logic [31:0] ins, input logic fl, input logic e_mr,
                             input logic [4:0] e_rd, input logic w_e, input logic [4:0] w_a,
                             input logic [31:0] w_d);
    if_id.instr = ins; if_id.pc = pc_cnt; if_id.pc_inc = pc_cnt + 32'd4;
    flush = fl; emr = e_mr; erd = e_rd; we = w_e; wa = w_a; wd = w_d;
    expv = model(if_id);
    @(negedge clk);
    stall_s = stall;
    @(posedge clk);
    #1;
    if (w_e && w_a != 5'd0) mregs[w_a] = w_d;
    pc_cnt = pc_cnt + 32'd4;
  endtask

  task automatic clear_inputs();
    if_id = '0; flush = 0; emr = 0; erd = '0; we = 0; wa = '0; wd = '0;
  endtask

  task automatic test_reset();
    if_id.instr = 32'h0050_0093; if_id.pc = 32'h100; if_id.pc_inc = 32'h104;
    we = 1; wa = 5'd1; wd = 32'h0000_FFFF;
    @(posedge clk); #1;
    compared++;
    if (id_ex !== '0) begin mismatched++; $display("FAIL rst_idex got=%h exp=0", id_ex); end
    compared++;
    if (illegal !== 1'b0) begin mismatched++; $display("FAIL rst_illegal got=%b exp=0", illegal); end
    if_id.instr = 32'h0000_007F;
    @(posedge clk); #1;
    compared++;
    if (illegal !== 1'b0) begin mismatched++; $display("FAIL rst_illegal_op got=%b exp=0", illegal); end
    clear_inputs();
    rst_n = 1'b1;
    drive_cycle(32'h0000_8333, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if (id_ex.valid !== 1'b1 || id_ex.rs1_data !== 32'd0) begin
      mismatched++; $display("FAIL rst_rf_clear got valid=%b rs1_data=%h exp 1/0", id_ex.valid, id_ex.rs1_data);
    end
  endtask

  task automatic test_addi();
    drive_cycle(32'h0050_0093, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if ({id_ex.valid, id_ex.rd, id_ex.imm, id_ex.reg_we, id_ex.alu_src_b} !==
        {1'b1, 5'd1, 32'd5, 1'b1, SRC_B_IMM}) begin
      mismatched++;
      $display("FAIL addi got valid=%b rd=%0d imm=%h we=%b srcb=%0d exp 1/1/5/1/imm",
               id_ex.valid, id_ex.rd, id_ex.imm, id_ex.reg_we, id_ex.alu_src_b);
    end
  endtask

  task automatic test_load_use();
    drive_cycle(32'h0011_01B3, 0, 1, 5'd2, 0, 5'd0, 32'd0);
    compared++;
    if (stall_s !== 1'b1) begin mismatched++; $display("FAIL lu_stall got=%b exp=1", stall_s); end
    compared++;
    if (ctl(id_ex) !== 7'd0) begin mismatched++; $display("FAIL lu_bubble got=%b exp=0000000", ctl(id_ex)); end
    drive_cycle(32'h0011_01B3, 0, 0, 5'd2, 0, 5'd0, 32'd0);
    compared++;
    if (stall_s !== 1'b0) begin mismatched++; $display("FAIL lu_release_stall got=%b exp=0", stall_s); end
    compared++;
    if (id_ex.valid !== 1'b1 || id_ex.rd !== 5'd3 || id_ex.alu_op !== ALU_ADD) begin
      mismatched++; $display("FAIL lu_issue got valid=%b rd=%0d op=%0d exp 1/3/add", id_ex.valid, id_ex.rd, id_ex.alu_op);
    end
  endtask

  task automatic test_flush_priority();
    drive_cycle(32'h0011_01B3, 1, 1, 5'd2, 0, 5'd0, 32'd0);
    compared++;
    if (stall_s !== 1'b0) begin mismatched++; $display("FAIL flush_stall got=%b exp=0", stall_s); end
    compared++;
    if (ctl(id_ex) !== 7'd0) begin mismatched++; $display("FAIL flush_bubble got=%b exp=0000000", ctl(id_ex)); end
  endtask

  task automatic test_wb_raw();
    drive_cycle(32'h0002_8333, 0, 0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF);
`ifdef PANDA_RF_BYPASS_EN
    compared++;
    if (stall_s !== 1'b0) begin mismatched++; $display("FAIL byp_stall got=%b exp=0", stall_s); end
    compared++;
    if (id_ex.valid !== 1'b1 || id_ex.rs1_data !== 32'hDEAD_BEEF) begin
      mismatched++; $display("FAIL byp_data got valid=%b rs1_data=%h exp 1/deadbeef", id_ex.valid, id_ex.rs1_data);
    end
`else
    compared++;
    if (stall_s !== 1'b1) begin mismatched++; $display("FAIL raw_stall got=%b exp=1", stall_s); end
    compared++;
    if (ctl(id_ex) !== 7'd0) begin mismatched++; $display("FAIL raw_bubble got=%b exp=0000000", ctl(id_ex)); end
    drive_cycle(32'h0002_8333, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if (stall_s !== 1'b0) begin mismatched++; $display("FAIL raw_release got=%b exp=0", stall_s); end
    compared++;
    if (id_ex.valid !== 1'b1 || id_ex.rs1_data !== 32'hDEAD_BEEF) begin
      mismatched++; $display("FAIL raw_data got valid=%b rs1_data=%h exp 1/deadbeef", id_ex.valid, id_ex.rs1_data);
    end
`endif
  endtask

  task automatic test_x0_write();
    drive_cycle(32'd0, 0, 0, 5'd0, 1, 5'd0, 32'h0000_1234);
    drive_cycle(32'h0000_0333, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if (id_ex.valid !== 1'b1 || id_ex.rs1_data !== 32'd0) begin
      mismatched++; $display("FAIL x0_read got valid=%b rs1_data=%h exp 1/0", id_ex.valid, id_ex.rs1_data);
    end
  endtask

  task automatic test_beq_illegal();
    drive_cycle(32'hFE00_0CE3, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if (id_ex.imm !== 32'hFFFF_FFF8 || id_ex.branch !== 1'b1 || id_ex.valid !== 1'b1 ||
        id_ex.branch_cond !== BR_EQ) begin
      mismatched++; $display("FAIL beq got imm=%h br=%b valid=%b cond=%0d exp fffffff8/1/1/eq",
                             id_ex.imm, id_ex.branch, id_ex.valid, id_ex.branch_cond);
    end
    drive_cycle(32'h0000_007F, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if (illegal !== 1'b1) begin mismatched++; $display("FAIL illegal_flag got=%b exp=1", illegal); end
    compared++;
    if (ctl(id_ex) !== 7'd0) begin mismatched++; $display("FAIL illegal_bubble got=%b exp=0000000", ctl(id_ex)); end
    drive_cycle(32'd0, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if (illegal !== 1'b0 || id_ex.valid !== 1'b0) begin
      mismatched++; $display("FAIL zero_instr got illegal=%b valid=%b exp 0/0", illegal, id_ex.valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  bad [5];
    bad = '{7'h7F, 7'h00, 7'h0B, 7'h2F, 7'h53};
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 13))
        0:  ins[6:0] = OPC_LUI;
        1:  ins[6:0] = OPC_AUIPC;
        2:  ins[6:0] = OPC_JAL;
        3:  ins[6:0] = OPC_JALR;
        4:  begin ins[6:0] = OPC_BRANCH; ins[14:12] = 3'($urandom_range(0, 5)); if (ins[14:12] >= 3'd2) ins[14:12] = ins[14:12] + 3'd2; end
        5:  begin ins[6:0] = OPC_LOAD; ins[14:12] = 3'($urandom_range(0, 4)); if (ins[14:12] == 3'd3) ins[14:12] = 3'd5; end
        6:  begin ins[6:0] = OPC_STORE; ins[14:12] = 3'($urandom_range(0, 2)); end
        7, 13: ins[6:0] = OPC_OP_IMM;
        8, 9: begin ins[6:0] = OPC_OP; ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
        10: ins[6:0] = $urandom_range(0, 1) ? OPC_MISC_MEM : OPC_SYSTEM;
        11: ins[6:0] = bad[$urandom_range(0, 4)];
        default: ins = 32'd0;
      endcase
      drive_cycle(ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom);
      compared++;
      if (stall_s !== expv.stall) begin
        mismatched++; $display("FAIL rnd_stall n=%0d instr=%h got=%b exp=%b", n, ins, stall_s, expv.stall);
      end
      compared++;
      if (illegal !== expv.illegal) begin
        mismatched++; $display("FAIL rnd_illegal n=%0d instr=%h got=%b exp=%b", n, ins, illegal, expv.illegal);
      end
      compared++;
      if (expv.bubble) begin
        if (ctl(id_ex) !== 7'd0) begin
          mismatched++; $display("FAIL rnd_bubble n=%0d instr=%h got=%b exp=0000000", n, ins, ctl(id_ex));
        end
      end else if (id_ex !== expv.rec) begin
        mismatched++; $display("FAIL rnd_record n=%0d instr=%h got=%h exp=%h", n, ins, id_ex, expv.rec);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(32'h0050_0093, 0, 0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF);
    if_id.instr = 32'h0011_01B3; flush = 0; emr = 1; erd = 5'd2; we = 0;
    #2;
    compared++;
    if (stall !== 1'b1) begin mismatched++; $display("FAIL mid_stall got=%b exp=1", stall); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (id_ex !== '0 || illegal !== 1'b0) begin
      mismatched++; $display("FAIL mid_rst_clear got=%h illegal=%b exp 0/0", id_ex, illegal);
    end
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    compared++;
    if (stall !== 1'b0) begin mismatched++; $display("FAIL post_rst_stall got=%b exp=0", stall); end
    drive_cycle(32'h0002_8333, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    compared++;
    if (id_ex.valid !== 1'b1 || id_ex.rs1_data !== 32'd0) begin
      mismatched++; $display("FAIL post_rst_rf got valid=%b rs1_data=%h exp 1/0", id_ex.valid, id_ex.rs1_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pc_cnt = 32'h0000_1000;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_load_use();
    test_flush_priority();
    test_wb_raw();
    test_x0_write();
    test_beq_illegal();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
